// File: rtl/envelope_follower_pkg.sv
// Shared constants and types for the envelope follower.
//   N_FILTERS   : number of filter-bank bands (default channel count)
//   SHIFT_W     : width of the attack/release shift coefficients
//   env_state_t : sequencer states IDLE -> RECTIFY -> UPDATE -> WRITE
package envelope_follower_pkg;

  localparam int unsigned N_FILTERS = 8;
  localparam int unsigned SHIFT_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECTIFY = 2'd1,
    UPDATE  = 2'd2,
    WRITE   = 2'd3
  } env_state_t;

endpackage

// File: rtl/envelope_follower_env_smoother.sv
// One-pole attack/release smoother step (purely combinational).
// Ports:
//   mag           in  W   rectified sample, 0 .. 2^(W-1)-1
//   env           in  W   current envelope, 0 .. 2^(W-1)-1
//   attack_shift  in  5   right-shift applied when mag > env
//   release_shift in  5   right-shift applied when mag <= env
//   next_c        out W   updated envelope, stays within [min(mag,env), max(mag,env)]
module envelope_follower_env_smoother
  import envelope_follower_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]       mag,
  input  logic [W-1:0]       env,
  input  logic [SHIFT_W-1:0] attack_shift,
  input  logic [SHIFT_W-1:0] release_shift,
  output logic [W-1:0]       next_c
);

  localparam int unsigned XW = W + 1;

  logic signed [XW-1:0] mag_x;
  logic signed [XW-1:0] env_x;
  logic signed [XW-1:0] diff_x;
  logic signed [XW-1:0] step_x;
  logic signed [XW-1:0] next_x;

  // Both operands are non-negative, so one extra bit keeps the difference exact;
  // shift 0 degenerates to next = mag.
  always_comb begin
    mag_x  = signed'({1'b0, mag});
    env_x  = signed'({1'b0, env});
    diff_x = '0;
    step_x = '0;
    next_x = env_x;
    if (mag_x > env_x) begin
      diff_x = mag_x - env_x;
      step_x = diff_x >>> attack_shift;
      next_x = env_x + step_x;
    end else begin
      diff_x = env_x - mag_x;
      step_x = diff_x >>> release_shift;
      next_x = env_x - step_x;
    end
  end

  // Result never exceeds 2^(W-1)-1, so dropping the guard bit is lossless.
  assign next_c = W'(next_x);

endmodule

// File: rtl/envelope_follower.sv
// Per-band envelope follower: rectifies each band sample of a frame and runs
// a one-pole attack/release smoother per channel on one shared datapath,
// then publishes all envelopes at once.
// Ports:
//   clk_in            in   system clock
//   rst_n_in          in   synchronous active-low reset
//   valid_in          in   frame strobe (ignored while busy)
//   band_channels     in   N_CH x W signed band samples
//   attack_shift      in   5-bit attack right-shift, captured on accept
//   release_shift     in   5-bit release right-shift, captured on accept
//   envelope_channels out  N_CH x W smoothed envelopes (>= 0), double-buffered
//   valid_out         out  one-cycle pulse when envelope_channels updates
//   busy              out  high while a frame is in progress
//   dropped_count     out  16-bit saturating count of ignored strobes
//                          (only with ENVELOPE_DROP_COUNT_EN defined)
module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int unsigned N_CH = N_FILTERS,
  parameter int unsigned W    = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      valid_in,
  input  logic [N_CH-1:0][W-1:0]    band_channels,
  input  logic [SHIFT_W-1:0]        attack_shift,
  input  logic [SHIFT_W-1:0]        release_shift,
  output logic [N_CH-1:0][W-1:0]    envelope_channels,
  output logic                      valid_out,
  output logic                      busy
`ifdef ENVELOPE_DROP_COUNT_EN
  ,
  output logic [15:0]               dropped_count
`endif
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

  env_state_t                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_CH-1:0][W-1:0]    snap_q, snap_d;
  logic [SHIFT_W-1:0]        atk_q, atk_d;
  logic [SHIFT_W-1:0]        rel_q, rel_d;
  logic [W-1:0]              mag_q, mag_d;
  logic [W-1:0]              next_q, next_d;
  logic [N_CH-1:0][W-1:0]    env_q, env_d;
  logic [N_CH-1:0][W-1:0]    env_out_q, env_out_d;
  logic                      valid_out_q, valid_out_d;
  logic                      busy_q, busy_d;

  logic [W-1:0]              sample_c;
  logic [W-1:0]              rect_c;
  logic [W-1:0]              smooth_next_c;

  // Full-wave rectifier; the most negative code saturates to the largest positive.
  always_comb begin
    sample_c = snap_q[idx_q];
    if (sample_c == MOST_NEG) begin
      rect_c = ~MOST_NEG;
    end else if (sample_c[W-1]) begin
      rect_c = W'(0) - sample_c;
    end else begin
      rect_c = sample_c;
    end
  end

  envelope_follower_env_smoother #(
    .W (W)
  ) u_smoother (
    .mag           (mag_q),
    .env           (env_q[idx_q]),
    .attack_shift  (atk_q),
    .release_shift (rel_q),
    .next_c        (smooth_next_c)
  );

  // Sequencer: three cycles per channel, publish on the last write.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    atk_d       = atk_q;
    rel_d       = rel_q;
    mag_d       = mag_q;
    next_d      = next_q;
    env_d       = env_q;
    env_out_d   = env_out_q;
    valid_out_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          snap_d  = band_channels;
          atk_d   = attack_shift;
          rel_d   = release_shift;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RECTIFY;
        end
      end
      RECTIFY: begin
        mag_d   = rect_c;
        state_d = UPDATE;
      end
      UPDATE: begin
        next_d  = smooth_next_c;
        state_d = WRITE;
      end
      WRITE: begin
        env_d[idx_q] = next_q;
        if (idx_q == LAST_IDX) begin
          // env_d already holds the word written this cycle.
          env_out_d   = env_d;
          valid_out_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RECTIFY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      atk_q       <= '0;
      rel_q       <= '0;
      mag_q       <= '0;
      next_q      <= '0;
      env_q       <= '0;
      env_out_q   <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      atk_q       <= atk_d;
      rel_q       <= rel_d;
      mag_q       <= mag_d;
      next_q      <= next_d;
      env_q       <= env_d;
      env_out_q   <= env_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
    end
  end

  assign envelope_channels = env_out_q;
  assign valid_out         = valid_out_q;
  assign busy              = busy_q;

`ifdef ENVELOPE_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  // Saturating count of strobes that arrive while a frame is in flight.
  always_comb begin
    drop_d = drop_q;
    if (valid_in && busy_q && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign dropped_count = drop_q;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// Directed testbench for envelope_follower: attack, release, rectifier edge
// cases, busy drop, mid-frame reset and back-to-back frames.
module tb_envelope_follower;
  import envelope_follower_pkg::*;

  localparam int unsigned N   = N_FILTERS;
  localparam int unsigned W   = 32;
  localparam int          LAT = 3 * N;

  typedef logic [N-1:0][W-1:0] frame_t;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         valid_in;
  frame_t       band_channels;
  logic [4:0]   attack_shift;
  logic [4:0]   release_shift;
  frame_t       envelope_channels;
  logic         valid_out;
  logic         busy;
`ifdef ENVELOPE_DROP_COUNT_EN
  logic [15:0]  dropped_count;
`endif

  int n_err = 0;
  int n_chk = 0;

  envelope_follower #(
    .N_CH (N),
    .W    (W)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .valid_in          (valid_in),
    .band_channels     (band_channels),
    .attack_shift      (attack_shift),
    .release_shift     (release_shift),
    .envelope_channels (envelope_channels),
    .valid_out         (valid_out),
    .busy              (busy)
`ifdef ENVELOPE_DROP_COUNT_EN
    ,
    .dropped_count     (dropped_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_env(input string tag, input logic [W-1:0] exp);
    for (int i = 0; i < int'(N); i++) begin
      check($sformatf("%s[%0d]", tag, i), 64'(envelope_channels[i]), 64'(exp));
    end
  endtask

  function automatic frame_t fill(input logic [W-1:0] v);
    frame_t f;
    for (int i = 0; i < int'(N); i++) f[i] = v;
    return f;
  endfunction

  // Accepts one frame, scrambles the inputs afterwards, and returns the number
  // of edges from the accepting edge to the first valid_out (-1 on timeout).
  task automatic run_frame(input frame_t f, input logic [4:0] a, input logic [4:0] r,
                           output int lat);
    band_channels = f;
    attack_shift  = a;
    release_shift = r;
    valid_in      = 1'b1;
    step();
    valid_in      = 1'b0;
    band_channels = fill('1);
    attack_shift  = 5'd31;
    release_shift = 5'd31;
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = -1;
    for (int c = 1; c <= LAT + 20; c++) begin
      step();
      if (valid_out) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    frame_t f;
    int     lat;
    int     npulse;
    int     first;

    rst_n_in      = 1'b0;
    valid_in      = 1'b0;
    band_channels = '0;
    attack_shift  = '0;
    release_shift = '0;
    repeat (3) step();
    check("reset_valid_out", 64'(valid_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check_all_env("reset_env", '0);
`ifdef ENVELOPE_DROP_COUNT_EN
    check("reset_dropped", 64'(dropped_count), 64'd0);
`endif
    rst_n_in = 1'b1;
    step();

    // Attack step: 0 -> 32768 -> 49152
    run_frame(fill(32'd65536), 5'd1, 5'd0, lat);
    check("attack1_latency", 64'(lat), 64'(LAT));
    check_all_env("attack1_env", 32'd32768);
    step();
    check("valid_out_one_cycle", 64'(valid_out), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("env_stable", 64'(envelope_channels[N-1]), 64'd32768);

    run_frame(fill(32'd65536), 5'd1, 5'd0, lat);
    check("attack2_latency", 64'(lat), 64'(LAT));
    check_all_env("attack2_env", 32'd49152);
    step();

    // Release: 49152 - (49152 >>> 2) = 36864
    run_frame(fill(32'd0), 5'd1, 5'd2, lat);
    check("release_latency", 64'(lat), 64'(LAT));
    check_all_env("release_env", 32'd36864);
    step();

    // Rectifier edges with instant tracking
    f    = fill(32'd0);
    f[0] = 32'h8000_0000;
    f[1] = 32'hFFFF_FF9C;
    run_frame(f, 5'd0, 5'd0, lat);
    check("rect_latency", 64'(lat), 64'(LAT));
    check("rect_most_neg", 64'(envelope_channels[0]), 64'd2147483647);
    check("rect_minus100", 64'(envelope_channels[1]), 64'd100);
    check("rect_zero", 64'(envelope_channels[2]), 64'd0);
    step();

    // Busy drop: strobes at 1, 5 and LAT-1 after accept are ignored
    band_channels = fill(32'd1000);
    attack_shift  = 5'd0;
    release_shift = 5'd0;
    valid_in      = 1'b1;
    step();
    band_channels = fill(32'd5000);
    npulse = 0;
    first  = -1;
    for (int c = 1; c <= LAT + 30; c++) begin
      valid_in = (c == 1) || (c == 5) || (c == LAT - 1);
      step();
      if (valid_out) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
    valid_in = 1'b0;
    check("drop_pulses", 64'(npulse), 64'd1);
    check("drop_latency", 64'(first), 64'(LAT));
    check_all_env("drop_env", 32'd1000);
`ifdef ENVELOPE_DROP_COUNT_EN
    check("dropped_count", 64'(dropped_count), 64'd3);
`endif

    // Reset while channel 2 is being processed
    band_channels = fill(32'd7777);
    valid_in      = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (6) step();
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check_all_env("midrst_env", '0);
`ifdef ENVELOPE_DROP_COUNT_EN
    check("midrst_dropped", 64'(dropped_count), 64'd0);
`endif
    npulse = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      step();
      if (valid_out) npulse++;
    end
    check("midrst_no_pulse", 64'(npulse), 64'd0);

    // Fresh frame from zero state, then a back-to-back accept on valid_out
    run_frame(fill(32'd65536), 5'd1, 5'd0, lat);
    check("after_rst_latency", 64'(lat), 64'(LAT));
    check_all_env("after_rst_env", 32'd32768);
    check("b2b_vout_high", 64'(valid_out), 64'd1);
    run_frame(fill(32'd65536), 5'd1, 5'd0, lat);
    check("b2b_latency", 64'(lat), 64'(LAT));
    check_all_env("b2b_env", 32'd49152);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
- Per-band envelope detector that feeds the mixer's envelope_channels input.
- Takes one frame of N_FILTERS signed band-pass modulator samples, full-wave rectifies each one, and applies a one-pole attack/release smoother per channel.
- Processes channels sequentially on a single shared datapath.
- Publishes all smoothed envelopes atomically with a one-cycle valid_out pulse.

Parameters:
- N_CH, default N_FILTERS (from constants), number of band channels.
- W, default 32, sample/envelope width in bits (signed).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, synchronous, active-low.
- valid_in  input  1  frame strobe; band_channels valid this cycle.
- band_channels  input  N_CH x W signed  filter-bank outputs for one frame.
- attack_shift  input  5  attack coefficient as right-shift; sampled on frame accept.
- release_shift  input  5  release coefficient as right-shift; sampled on frame accept.
- envelope_channels  output  N_CH x W signed  smoothed envelopes, always >= 0.
- valid_out  output  1  one-cycle pulse when envelope_channels has just updated.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n_in low at a clock edge):
  - all envelope state and envelope_channels = 0; valid_out = 0; busy = 0; state = IDLE.
  - Reset mid-frame aborts the frame. The published outputs are zeroed and no valid_out is issued.
- States: IDLE, RECTIFY, UPDATE, WRITE.
- IDLE:
  - On valid_in, snapshot band_channels, attack_shift and release_shift into internal registers.
  - idx = 0, busy = 1, go to RECTIFY.
- RECTIFY: mag = |sample[idx]|. The value -2^(W-1) saturates to 2^(W-1)-1. Go to UPDATE.
- UPDATE: env = state[idx]; all arithmetic in W+1 bits, arithmetic shift.
  - If mag > env: next = env + ((mag - env) >>> attack_shift).
  - Else: next = env - ((env - mag) >>> release_shift).
  - Shift 0 means next = mag (instant tracking).
  - Go to WRITE.
- WRITE: state[idx] = next.
  - If idx == N_CH-1: go to IDLE; copy all N_CH state words into envelope_channels in the same edge; valid_out = 1 for exactly one cycle; busy = 0.
  - Else: idx++, go to RECTIFY.
- Latency: 3*N_CH cycles from the accepting edge to valid_out high.
- Earliest next accept is the cycle valid_out is high: IDLE is reached on the same edge.
- envelope_channels stays stable between valid_out pulses. It is double-buffered from internal state, so the mixer can read it over many cycles.
- Busy handling: valid_in while busy is ignored. The in-flight snapshot and shifts are unaffected.
- Range: next always lies in [0, 2^(W-1)-1]; no overflow by construction. idx wraps only via the transition back to IDLE.

Optional Feature:
- Macro: ENVELOPE_DROP_COUNT_EN.
- Defined:
  - Adds output port dropped_count [15:0].
  - Increments on every cycle with valid_in=1 while busy=1; saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- constants package: N_FILTERS (existing); add typedef env_state_t for the 4-state enum.
- One sub-module is natural: env_smoother. It is the combinational UPDATE datapath: inputs mag, env, attack_shift, release_shift; output next. Keeping it separate allows exhaustive unit testing of the arithmetic.

Test Plan:
- Attack step: reset, then frames with all channels = 65536, attack_shift=1. First valid_out shows 32768 per channel, second 49152; valid_out arrives exactly 3*N_CH cycles after accept.
- Release: after the attack frames, frame with all channels = 0, release_shift=2 -> envelope 49152 drops to 36864.
- Rectify edge: channel0 = -2^31, attack_shift=0 -> envelope 2147483647. Channel1 = -100 -> envelope 100 with shift 0.
- Busy drop: valid_in pulsed at cycles 1, 5 and 3*N_CH-1 after accept -> only one valid_out and results from the first frame. With ENVELOPE_DROP_COUNT_EN, dropped_count = 3.
- Reset mid-frame: drop rst_n_in at idx = 2 -> envelope_channels = 0, no valid_out, busy = 0. Next frame processes normally from zero state.
- Back-to-back: valid_in asserted in the cycle valid_out is high -> accepted. Second valid_out follows exactly 3*N_CH cycles later.
